// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the scheduler state encoding, the default parameter values and
// a constant-evaluable ceiling-log2 helper used to size index and counter fields.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } sched_state_t;

    localparam int DEFAULT_N_REQ          = 4;
    localparam int DEFAULT_DATA_W         = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 8192;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(17) = 5.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Rotating-priority selector for the UART transmit scheduler.
// Picks the first asserted valid bit strictly after 'last', wrapping
// around, so the most recent winner has the lowest priority.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down to the nearest so the nearest valid index wins.
    always_comb begin
        winner = last;
        any    = 1'b0;
        idx    = last;
        for (int off = N; off >= 1; off--) begin
            idx = IDX_W'((int'(last) + off) % N);
            if (valid[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
// Each frame walks IDLE -> LOAD (accept pulse) -> SEND (start pulse) -> WAIT
// (until tx_done or the watchdog expires). A sticky timeout_err reports a
// transmitter that never completed; err_clr clears it.
// Optional feature: define UART_TX_SCHED_LOCK_EN to add req_lock, which lets
// the current owner keep the grant across frames for multi-byte packets.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ          = DEFAULT_N_REQ,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
`ifdef UART_TX_SCHED_LOCK_EN
    input  logic [N_REQ-1:0]          req_lock,
`endif
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_send,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [clog2(N_REQ)-1:0]   grant_id,
    output logic                      timeout_err,
    input  logic                      err_clr
);

    localparam int ID_W     = clog2(N_REQ);
    localparam int WD_W_RAW = clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W     = (WD_W_RAW < 1) ? 1 : WD_W_RAW;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   grant_q;
    logic [DATA_W-1:0] data_q;
    logic [WD_W-1:0]   wd_q;
    logic              err_q;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic [ID_W-1:0]   sel_id;
    logic              sel_valid;
    logic              wd_expire;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .valid  (req_valid),
        .last   (last_q),
        .winner (pick_id),
        .any    (pick_any)
    );

    // The watchdog fires on the WAIT cycle whose increment would reach the limit;
    // a coincident tx_done takes precedence and the frame counts as good.
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (state_q == WAIT) && !tx_done
                       && (wd_q == WD_LAST);

`ifdef UART_TX_SCHED_LOCK_EN
    logic locked_q;
    logic lock_hold;

    // The lock only holds while the owner keeps req_lock high; dropping it
    // lets round-robin choose again in the same IDLE cycle.
    assign lock_hold = locked_q && req_lock[grant_q];

    // While locked, only the owner may be granted; otherwise take the round-robin winner.
    always_comb begin
        sel_valid = pick_any;
        sel_id    = pick_id;
        if (lock_hold) begin
            sel_valid = req_valid[grant_q];
            sel_id    = grant_q;
        end
    end

    // Lock is captured from the owner's req_lock as WAIT completes and dropped on timeout or release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q <= 1'b0;
        end else if (state_q == IDLE && locked_q && !req_lock[grant_q]) begin
            locked_q <= 1'b0;
        end else if (state_q == WAIT && tx_done) begin
            locked_q <= req_lock[grant_q];
        end else if (wd_expire) begin
            locked_q <= 1'b0;
        end
    end
`else
    assign sel_valid = pick_any;
    assign sel_id    = pick_id;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the four-phase frame sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (sel_valid) state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: state_d = WAIT;
            WAIT: if (tx_done || wd_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner and its byte in IDLE; remember it as last grant once accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            data_q  <= '0;
            last_q  <= ID_W'(N_REQ - 1);
        end else begin
            if (state_q == IDLE && sel_valid) begin
                grant_q <= sel_id;
                data_q  <= req_data[sel_id*DATA_W +: DATA_W];
            end
            if (state_q == LOAD) begin
                last_q <= grant_q;
            end
        end
    end

    // Watchdog counter: cleared on SEND, saturating count during WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q == SEND) begin
            wd_q <= '0;
        end else if (state_q == WAIT && wd_q != WD_LIMIT) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Sticky timeout flag; a clear request beats a simultaneous set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end else if (wd_expire) begin
            err_q <= 1'b1;
        end
    end

    assign req_ready   = (state_q == LOAD) ? (N_REQ'(1) << grant_q) : '0;
    assign tx_send     = (state_q == SEND);
    assign busy        = (state_q != IDLE);
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (N_REQ=4, DATA_W=8, TIMEOUT_CYCLES=16).
// Expected grants come from a round-robin model over a pending-request mask.
// Lock frames are exercised when UART_TX_SCHED_LOCK_EN is defined.
module tb_uart_tx_scheduler;

    localparam int NR = 4;
    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic        err_clr;
`ifdef UART_TX_SCHED_LOCK_EN
    logic [3:0]  req_lock;
`endif

    int          vectors;
    int          miscompares;
    logic [3:0]  pend;
    logic [7:0]  bytes [NR];
    int          last_model;

    uart_tx_scheduler #(
        .N_REQ          (NR),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef UART_TX_SCHED_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ready   (req_ready),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        req_valid = pend;
        for (int i = 0; i < NR; i++) begin
            req_data[i*8 +: 8] = bytes[i];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_send"}, 32'(tx_send), 32'd0);
        checkOutput({tag, "_data"}, 32'(tx_data), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_grant"}, 32'(grant_id), 32'd0);
        checkOutput({tag, "_err"}, 32'(timeout_err), 32'd0);
    endtask

    // Round-robin rule: first pending index strictly after the last grant, wrapping.
    function automatic int model_pick(input logic [3:0] mask, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (mask[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // One complete frame from IDLE; done_after = 0 lets the watchdog expire.
    task automatic do_frame(input int exp_id, input int done_after, input bit clr_at_timeout);
        logic [7:0] exp_byte;
        exp_byte = bytes[exp_id];
        applyStimulus();
        step();
        checkOutput("load_ready", 32'(req_ready), 32'(1 << exp_id));
        checkOutput("load_grant", 32'(grant_id), 32'(exp_id));
        checkOutput("load_data", 32'(tx_data), 32'(exp_byte));
        checkOutput("load_send", 32'(tx_send), 32'd0);
        pend[exp_id]  = 1'b0;
        bytes[exp_id] = 8'($urandom);
        applyStimulus();
        step();
        checkOutput("send_pulse", 32'(tx_send), 32'd1);
        checkOutput("send_ready", 32'(req_ready), 32'd0);
        checkOutput("send_data", 32'(tx_data), 32'(exp_byte));
        step();
        checkOutput("wait_send", 32'(tx_send), 32'd0);
        checkOutput("wait_busy", 32'(busy), 32'd1);
        if (done_after > 0) begin
            repeat (done_after - 1) step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checkOutput("done_busy", 32'(busy), 32'd0);
            checkOutput("done_err", 32'(timeout_err), 32'd0);
        end else begin
            repeat (TO - 1) step();
            checkOutput("wd_pre_busy", 32'(busy), 32'd1);
            checkOutput("wd_pre_err", 32'(timeout_err), 32'd0);
            if (clr_at_timeout) err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            checkOutput("wd_busy", 32'(busy), 32'd0);
            checkOutput("wd_err", 32'(timeout_err), clr_at_timeout ? 32'd0 : 32'd1);
        end
        last_model = exp_id;
    endtask

    initial begin
        int exp;
        vectors     = 0;
        miscompares = 0;
        pend        = '0;
        last_model  = NR - 1;
        tx_done     = 1'b0;
        err_clr     = 1'b0;
        rst         = 1'b1;
        for (int i = 0; i < NR; i++) bytes[i] = 8'h00;
`ifdef UART_TX_SCHED_LOCK_EN
        req_lock    = '0;
`endif
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetOutputs("reset");
        $display("[TB] reset values checked");

        // Round-robin with all four requesting, req0 re-requesting after its grant.
        pend = 4'hF;
        for (int i = 0; i < NR; i++) bytes[i] = 8'(8'hA0 + i);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                pend[0]  = 1'b1;
                bytes[0] = 8'hA4;
            end
            do_frame(k % NR, 5 + k, 1'b0);
        end

        // Single requester carrying 0x55.
        pend     = 4'b0001;
        bytes[0] = 8'h55;
        do_frame(0, 10, 1'b0);

        // Watchdog expiry, then clear.
        pend     = 4'b0100;
        bytes[2] = 8'h3A;
        do_frame(2, 0, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checkOutput("err_clr", 32'(timeout_err), 32'd0);

        // tx_done on the timeout cycle wins.
        pend     = 4'b1000;
        bytes[3] = 8'hC7;
        do_frame(3, TO, 1'b0);

        // tx_done pulse in IDLE is ignored.
        pend = '0;
        applyStimulus();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checkOutput("idle_done_busy", 32'(busy), 32'd0);
        checkOutput("idle_done_send", 32'(tx_send), 32'd0);
        step();
        checkOutput("idle_done_busy2", 32'(busy), 32'd0);

        // err_clr held on the timeout cycle keeps the flag low.
        pend     = 4'b0001;
        bytes[0] = 8'h99;
        do_frame(0, 0, 1'b1);

        // Randomized traffic against the round-robin model.
        for (int f = 0; f < 24; f++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]  = 1'b1;
                    bytes[i] = 8'($urandom);
                end
            end
            if (pend == 4'b0000) begin
                pend[f % NR]  = 1'b1;
                bytes[f % NR] = 8'($urandom);
            end
            exp = model_pick(pend, last_model);
            do_frame(exp, $urandom_range(1, TO - 1), 1'b0);
        end
        while (pend != 4'b0000) begin
            exp = model_pick(pend, last_model);
            do_frame(exp, 3, 1'b0);
        end

`ifdef UART_TX_SCHED_LOCK_EN
        // req1 locks for three bytes while req2 waits, then releases.
        req_lock = 4'b0010;
        pend     = 4'b0010;
        bytes[1] = 8'hB0;
        do_frame(1, 4, 1'b0);
        pend     = 4'b0110;
        bytes[1] = 8'hB1;
        bytes[2] = 8'hC0;
        do_frame(1, 4, 1'b0);
        pend[1]  = 1'b1;
        bytes[1] = 8'hB2;
        do_frame(1, 4, 1'b0);
        applyStimulus();
        step();
        checkOutput("lock_hold_busy", 32'(busy), 32'd0);
        step();
        checkOutput("lock_hold_busy2", 32'(busy), 32'd0);
        req_lock = 4'b0000;
        do_frame(2, 4, 1'b0);
`endif

        // Reset while waiting on the transmitter.
        pend = 4'b0110;
        for (int i = 0; i < NR; i++) bytes[i] = 8'($urandom);
        exp = model_pick(pend, last_model);
        applyStimulus();
        step();
        checkOutput("rstwait_grant", 32'(grant_id), 32'(exp));
        pend[exp] = 1'b0;
        applyStimulus();
        step();
        step();
        checkOutput("rstwait_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        last_model = NR - 1;
        pend[0]    = 1'b1;
        bytes[0]   = 8'h3C;
        do_frame(0, 6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
